// File: rtl/cv32e40p_pkg.sv
// Shared types for the core sleep sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SETTLE  = 3'd1,
        OFF_REQ = 3'd2,
        GATED   = 3'd3,
        ON_REQ  = 3'd4,
        RESUME  = 3'd5
    } sleep_seq_state_e;

    localparam int unsigned      SLEEP_DLY_W      = 8;
    localparam logic [2:0]       SLEEP_STATE_PERR = 3'b111;

    // Delays are expressed as cycle counts; the down-counter is loaded with count-1.
    function automatic logic [SLEEP_DLY_W-1:0] dly_load_val(input int unsigned d);
        return SLEEP_DLY_W'(d - 1);
    endfunction

endpackage

// File: rtl/cv32e40p_sleep_dly_cnt.sv
// Loadable down-counter with zero flag, used for sleep entry/resume delays.
// Latency: load/decrement take effect at the next clk_i edge; zero is combinational from the count.
// Backpressure: none; decrement holds at zero.
module cv32e40p_sleep_dly_cnt
    import cv32e40p_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic [SLEEP_DLY_W-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [SLEEP_DLY_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - SLEEP_DLY_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cv32e40p_sleep_seq.sv
// Core sleep sequencer: debounces core_sleep_i, runs a four-phase clock-off handshake, releases wake.
// Latency: sleep rise to clk_off_req_o is ENTRY_DELAY+1 cycles; ack fall to wake_pulse_o is RESUME_DELAY cycles.
// Backpressure: waits indefinitely on clk_off_ack_i in OFF_REQ/ON_REQ; wake never drops an outstanding request.
module cv32e40p_sleep_seq
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ENTRY_DELAY  = 4,
    parameter int unsigned RESUME_DELAY = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             core_sleep_i,
    input  logic [31:0]      irq_pending_i,
    input  logic [31:0]      irq_mask_i,
    input  logic             debug_req_i,
    output logic             clk_off_req_o,
    input  logic             clk_off_ack_i,
    output logic             sleeping_o,
    output logic             wake_pulse_o,
    output logic [CNT_W-1:0] sleep_cnt_o,
    output logic [2:0]       state_o
);

    localparam logic [SLEEP_DLY_W-1:0] ENTRY_LOAD  = dly_load_val(ENTRY_DELAY);
    localparam logic [SLEEP_DLY_W-1:0] RESUME_LOAD = dly_load_val(RESUME_DELAY);

    sleep_seq_state_e       state_q, state_d;
    logic                   wake;
    logic                   want_sleep;
    logic                   dly_load;
    logic [SLEEP_DLY_W-1:0] dly_val;
    logic                   dly_dec;
    logic                   dly_zero;
    logic                   req_q;
    logic                   err_sticky_q;
    logic                   err_show_q;
    logic                   proto_err;
    logic                   entry_done;
    logic [CNT_W-1:0]       sleep_cnt_q;

    assign wake       = debug_req_i | (|(irq_pending_i & irq_mask_i));
    assign want_sleep = core_sleep_i & ~wake;
    assign entry_done = (state_q == OFF_REQ) && clk_off_ack_i;
    // An ack outside the handshake window is a SoC protocol violation.
    assign proto_err  = clk_off_ack_i &&
                        ((state_q == RUN) || (state_q == SETTLE) || (state_q == RESUME));

    cv32e40p_sleep_dly_cnt u_dly_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (dly_load),
        .load_val (dly_val),
        .dec      (dly_dec),
        .zero     (dly_zero)
    );

    always_comb begin
        state_d  = state_q;
        dly_load = 1'b0;
        dly_val  = ENTRY_LOAD;
        dly_dec  = 1'b0;
        case (state_q)
            RUN: begin
                if (want_sleep) begin
                    state_d  = SETTLE;
                    dly_load = 1'b1;
                    dly_val  = ENTRY_LOAD;
                end
            end
            SETTLE: begin
                if (!want_sleep)   state_d = RUN;
                else if (dly_zero) state_d = OFF_REQ;
                else               dly_dec = 1'b1;
            end
            OFF_REQ: begin
                if (clk_off_ack_i) state_d = GATED;
            end
            GATED: begin
                if (!want_sleep) state_d = ON_REQ;
            end
            ON_REQ: begin
                if (!clk_off_ack_i) begin
                    state_d  = RESUME;
                    dly_load = 1'b1;
                    dly_val  = RESUME_LOAD;
                end
            end
            RESUME: begin
                if (dly_zero) state_d = RUN;
                else          dly_dec = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            req_q        <= 1'b0;
            sleep_cnt_q  <= '0;
            err_sticky_q <= 1'b0;
            err_show_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d == OFF_REQ) || (state_d == GATED);
            if (entry_done && (sleep_cnt_q != '1)) begin
                sleep_cnt_q <= sleep_cnt_q + CNT_W'(1);
            end
            err_show_q <= proto_err & ~err_sticky_q;
            if (proto_err) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign clk_off_req_o = req_q;
    assign sleeping_o    = (state_q == OFF_REQ) || (state_q == GATED) || (state_q == ON_REQ);
    assign wake_pulse_o  = (state_q == RESUME) && dly_zero;
    assign sleep_cnt_o   = sleep_cnt_q;
    assign state_o       = err_show_q ? SLEEP_STATE_PERR : state_q;

endmodule

// File: tb/tb_cv32e40p_sleep_seq.sv
// Bench for cv32e40p_sleep_seq: directed vector table, multi-cycle corner sequences,
// counter saturation on a narrow instance, then randomized traffic against a reference model.
module tb_cv32e40p_sleep_seq;

    localparam int ED = 4;
    localparam int RD = 2;

    localparam int P_RUN = 0, P_SETTLE = 1, P_OFF = 2, P_GATED = 3, P_ON = 4, P_RESUME = 5;

    logic        clk_i;
    logic        rst_i;
    logic        core_sleep_i;
    logic [31:0] irq_pending_i;
    logic [31:0] irq_mask_i;
    logic        debug_req_i;
    logic        clk_off_req_o;
    logic        clk_off_ack_i;
    logic        sleeping_o;
    logic        wake_pulse_o;
    logic [15:0] sleep_cnt_o;
    logic [2:0]  state_o;

    logic        s_core_sleep;
    logic        s_dbg;
    logic [31:0] zero32;
    logic        s_req;
    wire logic   s_ack;
    logic        s_sleeping;
    logic        s_pulse;
    logic [2:0]  s_cnt;
    logic [2:0]  s_state;

    int checks = 0;
    int errors = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    cv32e40p_sleep_seq #(.ENTRY_DELAY(ED), .RESUME_DELAY(RD), .CNT_W(16)) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_sleep_i  (core_sleep_i),
        .irq_pending_i (irq_pending_i),
        .irq_mask_i    (irq_mask_i),
        .debug_req_i   (debug_req_i),
        .clk_off_req_o (clk_off_req_o),
        .clk_off_ack_i (clk_off_ack_i),
        .sleeping_o    (sleeping_o),
        .wake_pulse_o  (wake_pulse_o),
        .sleep_cnt_o   (sleep_cnt_o),
        .state_o       (state_o)
    );

    // Narrow counter instance with an instantly-following ack, used for saturation.
    assign s_ack = s_req;
    cv32e40p_sleep_seq #(.ENTRY_DELAY(1), .RESUME_DELAY(1), .CNT_W(3)) u_sat (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_sleep_i  (s_core_sleep),
        .irq_pending_i (zero32),
        .irq_mask_i    (zero32),
        .debug_req_i   (s_dbg),
        .clk_off_req_o (s_req),
        .clk_off_ack_i (s_ack),
        .sleeping_o    (s_sleeping),
        .wake_pulse_o  (s_pulse),
        .sleep_cnt_o   (s_cnt),
        .state_o       (s_state)
    );

    typedef struct packed {
        logic        cs;
        logic [31:0] irq;
        logic [31:0] mask;
        logic        dbg;
        logic        ack;
        logic        e_req;
        logic        e_slp;
        logic        e_pulse;
        logic [2:0]  e_state;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int m_ph, m_t, m_cnt;
    bit m_sticky, m_show;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cs, input logic [31:0] irq, input logic [31:0] mask,
                         input logic dbg, input logic ack);
        core_sleep_i  = cs;
        irq_pending_i = irq;
        irq_mask_i    = mask;
        debug_req_i   = dbg;
        clk_off_ack_i = ack;
    endtask

    function automatic vec_t mk(input logic cs, input logic [31:0] irq, input logic [31:0] mask,
                                input logic dbg, input logic ack, input logic rq, input logic sl,
                                input logic pu, input logic [2:0] st, input logic [15:0] cn);
        vec_t v;
        v = '{cs, irq, mask, dbg, ack, rq, sl, pu, st, cn};
        return v;
    endfunction

    task automatic model_step(input bit cs, input bit w, input bit ack);
        bit quiet;
        quiet  = cs && !w;
        m_show = 1'b0;
        if (ack && (m_ph == P_RUN || m_ph == P_SETTLE || m_ph == P_RESUME)) begin
            m_show   = !m_sticky;
            m_sticky = 1'b1;
        end
        case (m_ph)
            P_RUN:    if (quiet) begin m_ph = P_SETTLE; m_t = 0; end
            P_SETTLE: if (!quiet) m_ph = P_RUN;
                      else if (m_t == ED - 1) m_ph = P_OFF;
                      else m_t++;
            P_OFF:    if (ack) begin m_ph = P_GATED; if (m_cnt < 65535) m_cnt++; end
            P_GATED:  if (!quiet) m_ph = P_ON;
            P_ON:     if (!ack) begin m_ph = P_RESUME; m_t = 0; end
            default:  if (m_t == RD - 1) m_ph = P_RUN; else m_t++;
        endcase
    endtask

    function automatic logic [31:0] model_outs();
        logic rq, sl, pu;
        logic [2:0] st;
        rq = (m_ph == P_OFF) || (m_ph == P_GATED);
        sl = rq || (m_ph == P_ON);
        pu = (m_ph == P_RESUME) && (m_t == RD - 1);
        st = m_show ? 3'd7 : 3'(m_ph);
        return {10'd0, rq, sl, pu, st, 16'(m_cnt)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int held;
        vec_t v;
        zero32       = '0;
        s_dbg        = 1'b0;
        s_core_sleep = 1'b0;
        rst_i        = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset.req",   32'(clk_off_req_o), 0);
        chk("reset.slp",   32'(sleeping_o),    0);
        chk("reset.pulse", 32'(wake_pulse_o),  0);
        chk("reset.state", 32'(state_o),       0);
        chk("reset.cnt",   32'(sleep_cnt_o),   0);
        rst_i = 1'b0;

        // Abort in SETTLE, then full sleep with irq wake and 2-cycle ack latency
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1, 0, 3, 1));
        tbl.push_back(mk(1, 32'h80, 32'h80, 0, 1,  0, 1, 0, 4, 1));
        tbl.push_back(mk(1, 32'h80, 32'h80, 0, 1,  0, 1, 0, 4, 1));
        tbl.push_back(mk(1, 32'h80, 32'h80, 0, 0,  0, 0, 0, 5, 1));
        tbl.push_back(mk(1, 32'h80, 32'h80, 0, 0,  0, 0, 1, 5, 1));
        tbl.push_back(mk(1, 32'h80, 32'h80, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.cs, v.irq, v.mask, v.dbg, v.ack);
            tick();
            chk($sformatf("vec%0d.req", i),   32'(clk_off_req_o), 32'(v.e_req));
            chk($sformatf("vec%0d.slp", i),   32'(sleeping_o),    32'(v.e_slp));
            chk($sformatf("vec%0d.pulse", i), 32'(wake_pulse_o),  32'(v.e_pulse));
            chk($sformatf("vec%0d.state", i), 32'(state_o),       32'(v.e_state));
            chk($sformatf("vec%0d.cnt", i),   32'(sleep_cnt_o),   32'(v.e_cnt));
        end

        // Debug wake while the clock-off request is outstanding
        drive(1, 0, 0, 0, 0);
        repeat (ED + 1) tick();
        chk("dbg.req_rise", 32'(clk_off_req_o), 1);
        drive(1, 0, 0, 1, 0);
        tick();
        chk("dbg.hold_state", 32'(state_o), 2);
        tick();
        chk("dbg.hold_req", 32'(clk_off_req_o), 1);
        drive(1, 0, 0, 1, 1);
        tick();
        chk("dbg.gated", 32'(state_o), 3);
        chk("dbg.cnt", 32'(sleep_cnt_o), 2);
        tick();
        chk("dbg.on_req", 32'(state_o), 4);
        chk("dbg.req_fall", 32'(clk_off_req_o), 0);
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("dbg.pulse", 32'(wake_pulse_o), 1);
        tick();
        chk("dbg.run", 32'(state_o), 0);

        // Masked interrupts never wake
        drive(1, 32'hFFFF_FFFF, 0, 0, 0);
        repeat (ED + 1) tick();
        chk("mask.req_rise", 32'(clk_off_req_o), 1);
        clk_off_ack_i = 1'b1;
        tick();
        chk("mask.cnt", 32'(sleep_cnt_o), 3);
        held = 0;
        repeat (100) begin
            tick();
            if (state_o == 3'd3) held++;
        end
        chk("mask.hold", 32'(held), 100);
        drive(0, 32'hFFFF_FFFF, 0, 0, 1);
        tick();
        clk_off_ack_i = 1'b0;
        repeat (3) tick();
        chk("mask.run", 32'(state_o), 0);

        // Reset while gated, late ack, then a clean cycle
        drive(1, 0, 0, 0, 0);
        repeat (ED + 1) tick();
        clk_off_ack_i = 1'b1;
        tick();
        chk("rst.gated", 32'(state_o), 3);
        rst_i = 1'b1;
        tick();
        chk("rst.req", 32'(clk_off_req_o), 0);
        chk("rst.slp", 32'(sleeping_o), 0);
        chk("rst.state", 32'(state_o), 0);
        chk("rst.cnt", 32'(sleep_cnt_o), 0);
        rst_i = 1'b0;
        core_sleep_i = 1'b0;
        tick();
        chk("rst.err_flag", 32'(state_o), 7);
        tick();
        chk("rst.err_once", 32'(state_o), 0);
        drive(1, 0, 0, 0, 0);
        repeat (ED + 1) tick();
        chk("rst.req_again", 32'(clk_off_req_o), 1);
        clk_off_ack_i = 1'b1;
        tick();
        chk("rst.cnt_again", 32'(sleep_cnt_o), 1);
        core_sleep_i = 1'b0;
        tick();
        chk("rst.on_req", 32'(state_o), 4);
        clk_off_ack_i = 1'b0;
        tick();
        tick();
        chk("rst.pulse", 32'(wake_pulse_o), 1);
        tick();
        chk("rst.run", 32'(state_o), 0);

        // Entry counter saturates at all-ones (3-bit instance)
        for (int n = 1; n <= 11; n++) begin
            s_core_sleep = 1'b1;
            k = 0;
            while (s_state != 3'd3 && k < 20) begin tick(); k++; end
            chk($sformatf("sat%0d.enter", n), 32'(s_state), 3);
            s_core_sleep = 1'b0;
            k = 0;
            while (s_state != 3'd0 && k < 20) begin tick(); k++; end
            chk($sformatf("sat%0d.exit", n), 32'(s_state), 0);
            chk($sformatf("sat%0d.cnt", n), 32'(s_cnt), (n < 7) ? n : 7);
        end

        // Randomized traffic with a level-following, randomly delayed SoC ack
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        rst_i = 1'b0;
        m_ph = P_RUN; m_t = 0; m_cnt = 0; m_sticky = 1'b0; m_show = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) core_sleep_i = ~core_sleep_i;
            irq_pending_i = ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            if ($urandom_range(0, 31) == 0) irq_mask_i = $urandom;
            debug_req_i = ($urandom_range(0, 63) == 0);
            if ((clk_off_ack_i != clk_off_req_o) && ($urandom_range(0, 1) == 1))
                clk_off_ack_i = clk_off_req_o;
            model_step(core_sleep_i, debug_req_i || ((irq_pending_i & irq_mask_i) != 0), clk_off_ack_i);
            tick();
            chk($sformatf("rand%0d", c),
                {10'd0, clk_off_req_o, sleeping_o, wake_pulse_o, state_o, sleep_cnt_o},
                model_outs());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
